// File: rtl/fadd_rr_sched.sv
// Round-robin front end sharing one pipelined FP add/sub unit among NREQ requesters.
// A tag shadow pipeline matched to the adder latency returns each sum with its requester id.
module fadd_rr_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  input  logic [NREQ*2-1:0] req_rm,
  output logic              fa_valid,
  output logic [31:0]       fa_a,
  output logic [31:0]       fa_b,
  output logic              fa_sub,
  output logic [1:0]        fa_rm,
  input  logic [31:0]       fa_s,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [31:0]       res_s,
  output logic              busy
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] idx;
  logic           gnt_found;
  logic           grant;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic           sel_sub;
  logic [1:0]     sel_rm;
  logic [LAT:0]   tag_v;
  logic [IDW-1:0] tag_id [0:LAT];

  // Search starts one past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign grant = gnt_found & en & ~rst;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    sel_rm  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_sub = req_sub[i];
        sel_rm  = req_rm[2*i +: 2];
      end
    end
  end

  // Stage 0 of the tag pipe lines up with the adder input registers; stages 1..LAT track the adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= IDW'(NREQ - 1);
      fa_a   <= '0;
      fa_b   <= '0;
      fa_sub <= 1'b0;
      fa_rm  <= '0;
      for (int k = 0; k <= LAT; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0] <= grant;
      if (grant) begin
        rr_ptr    <= gnt_idx;
        tag_id[0] <= gnt_idx;
        fa_a      <= sel_a;
        fa_b      <= sel_b;
        fa_sub    <= sel_sub;
        fa_rm     <= sel_rm;
      end
      for (int k = 1; k <= LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign fa_valid  = tag_v[0];
  assign busy      = |tag_v;
  assign res_valid = tag_v[LAT];
  assign res_id    = tag_id[LAT];
  assign res_s     = fa_s;

endmodule
